fb_axi_writer: RTL and testbench

//  AXI3 burst write master that streams 32-bit pixels into a linear DRAM framebuffer through the fpga2hps bridge.
//  It is the write-side counterpart of the framebuffer read path.

---
 rtl/fb_axi_writer.sv | 239 +++++++++++++++++++++++
 tb/tb_fb_axi_writer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_axi_writer.sv
// fb_axi_writer: AXI3 write master that streams 32-bit pixel words from an
// input FIFO into a linear DRAM framebuffer as fixed-length INCR bursts.
// Bursts are issued only when the whole burst is already buffered, so the W
// channel never starves. The write address wraps back to the frame start at
// the end of every frame. Completed frames and bad write responses are
// reported on frame_done and err.
module fb_axi_writer #(
  parameter logic [31:0] START_ADDR      = 32'h1000_0000,
  parameter int unsigned FRAME_BYTES     = 640*480*4,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [7:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [7:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        frame_done,
  output logic        err
);

  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = PTR_W + 1;
  localparam int unsigned OUT_W        = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned FRAME_BURSTS = FRAME_BYTES / (BURST_LEN * 4);
  localparam int unsigned BC_W         = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

  localparam logic [31:0]      BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0]      END_ADDR    = START_ADDR + 32'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] FIFO_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BURST_WORDS = CNT_W'(BURST_LEN);
  localparam logic [OUT_W-1:0] OUT_MAX     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [3:0]       LAST_BEAT   = 4'(BURST_LEN - 1);
  localparam logic [BC_W-1:0]  BC_LAST     = BC_W'(FRAME_BURSTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ready_en;
  logic [3:0]        beat;
  logic [OUT_W-1:0]  outstanding;
  logic [BC_W-1:0]   burst_cnt;
  logic [31:0]       awaddr_inc;
  logic              push;
  logic              pop;
  logic              aw_hs;
  logic              b_hs;
  logic              b_ok;
  logic              unused_bid;

  // Fixed AXI attributes.
  assign awid       = 8'h00;
  assign awlen      = LAST_BEAT;
  assign awsize     = 3'b010;
  assign awburst    = 2'b01;
  assign awcache    = 4'b0011;
  assign awprot     = 3'b000;
  assign wid        = 8'h00;
  assign wstrb      = 4'hF;
  assign bready     = 1'b1;
  assign unused_bid = ^bid;

  // Channel valids are pure decodes of the state register.
  assign awvalid = (state == S_ADDR);
  assign wvalid  = (state == S_DATA);
  assign wlast   = (state == S_DATA) && (beat == LAST_BEAT);

  // in_ready looks only at the registered count, never at a same-cycle pop.
  assign in_ready = ready_en && (count != FIFO_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = wvalid && wready;
  assign aw_hs    = awvalid && awready;
  assign b_hs     = bvalid;
  // A response with nothing outstanding is a protocol error and is not counted.
  assign b_ok     = b_hs && (outstanding != '0);

  assign wdata      = mem[rd_ptr];
  assign frame_done = b_ok && (burst_cnt == BC_LAST);
  assign awaddr_inc = awaddr + BURST_BYTES;

  // FIFO storage write port; contents need no reset because count gates use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and the post-reset input enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Burst FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst FSM next state: issue only when a full burst is buffered and a slot is free.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if ((count >= BURST_WORDS) && (outstanding < OUT_MAX)) begin
          state_nxt = S_ADDR;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (aw_hs) begin
          state_nxt = S_DATA;
        end else begin
          state_nxt = S_ADDR;
        end
      end
      S_DATA: begin
        if (pop && (beat == LAST_BEAT)) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DATA;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst address, advanced on each AW handshake and wrapped at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr <= START_ADDR;
    end else if (aw_hs) begin
      if (awaddr_inc == END_ADDR) begin
        awaddr <= START_ADDR;
      end else begin
        awaddr <= awaddr_inc;
      end
    end
  end

  // Beat index within the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= 4'd0;
    end else if (pop) begin
      if (beat == LAST_BEAT) begin
        beat <= 4'd0;
      end else begin
        beat <= beat + 4'd1;
      end
    end
  end

  // Outstanding burst count; simultaneous AW and valid B cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_ok})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Completed-burst counter within the frame, wrapping at the frame length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (b_ok) begin
      if (burst_cnt == BC_LAST) begin
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + BC_W'(1);
      end
    end
  end

  // Sticky error: bad response code or a response nobody asked for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (b_hs && ((bresp != 2'b00) || (outstanding == '0))) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_axi_writer.sv
// tb_fb_axi_writer: directed tests for fb_axi_writer with a small frame
// (4 bursts) so address wrap and frame_done are reachable quickly.
module tb_fb_axi_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b1;
  logic [7:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b1;
  logic [7:0]  bid = 8'h00;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        frame_done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  bit          wl_log[$];
  int          pend = 0;
  int          b_cnt = 0;
  int          fd_cnt = 0;
  int          fd_at = 0;
  int          b_err_at = 0;
  bit          b_hold = 1'b0;

  fb_axi_writer #(
    .START_ADDR(32'h1000_0000),
    .FRAME_BYTES(256),
    .BURST_LEN(16),
    .FIFO_DEPTH(64),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  // Bus monitor: logs handshakes that will complete at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (awvalid && awready) aw_log.push_back(awaddr);
        if (wvalid && wready) begin
          w_log.push_back(wdata);
          wl_log.push_back(wlast);
          if (wlast) pend++;
        end
        if (bvalid) begin
          b_cnt++;
          pend--;
          if (frame_done) begin
            fd_cnt++;
            fd_at = b_cnt;
          end
        end
      end
    end
  end

  // B responder: answers each completed burst one cycle later unless held.
  initial begin
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bvalid = 1'b0;
        bresp  = 2'b00;
      end else if (pend > 0 && !b_hold) begin
        bvalid = 1'b1;
        bresp  = (b_cnt + 1 == b_err_at) ? 2'b10 : 2'b00;
      end else begin
        bvalid = 1'b0;
        bresp  = 2'b00;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    awready  = 1'b1;
    wready   = 1'b1;
    b_hold   = 1'b0;
    b_err_at = 0;
    repeat (3) @(posedge clk);
    #1;
    pend = 0; b_cnt = 0; fd_cnt = 0; fd_at = 0;
    aw_log.delete(); w_log.delete(); wl_log.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [31:0] base, input int budget, output int acc);
    int   cyc;
    logic rdy;
    cyc = 0;
    acc = 0;
    while (acc < n && cyc < budget) begin
      in_valid = 1'b1;
      in_data  = base + 32'(acc);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) acc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int nwords, input string name);
    int cyc;
    cyc = 0;
    while (!(w_log.size() >= nwords && pend == 0 && !bvalid && !awvalid && !wvalid) && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL %s_drain: timeout with %0d words seen, required %0d", name, w_log.size(), nwords);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || wlast !== 1'b0 || err !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_reset: awvalid=%b wvalid=%b wlast=%b err=%b frame_done=%b, all required 0",
               awvalid, wvalid, wlast, err, frame_done);
    end
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if (awaddr !== 32'h1000_0000) begin
      errors++; $display("FAIL reset_awaddr: got %h required 10000000", awaddr);
    end
    checks++;
    if (awlen !== 4'hF || awsize !== 3'b010 || awburst !== 2'b01 || awcache !== 4'b0011 ||
        awprot !== 3'b000 || awid !== 8'h00 || wid !== 8'h00 || wstrb !== 4'hF || bready !== 1'b1) begin
      errors++;
      $display("FAIL reset_constants: awlen=%h awsize=%b awburst=%b awcache=%b awprot=%b wstrb=%h bready=%b",
               awlen, awsize, awburst, awcache, awprot, wstrb, bready);
    end
  endtask

  task automatic test_single_burst();
    int acc;
    do_reset();
    push_words(16, 32'h0, 200, acc);
    wait_drain(16, "single");
    checks++;
    if (aw_log.size() != 1 || aw_log[0] !== 32'h1000_0000) begin
      errors++; $display("FAIL single_aw: %0d AW, first %h, required 1 AW at 10000000", aw_log.size(), aw_log[0]);
    end
    checks++;
    if (w_log.size() != 16) begin
      errors++; $display("FAIL single_count: got %0d beats required 16", w_log.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (w_log[i] !== 32'(i) || wl_log[i] !== (i == 15)) begin
        errors++;
        $display("FAIL single_beat%0d: data %h last %b, required %h last %b", i, w_log[i], wl_log[i], 32'(i), (i == 15));
      end
    end
  endtask

  task automatic test_frame_wrap();
    int          acc;
    logic [31:0] exp_aw [5];
    exp_aw = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080, 32'h1000_00C0, 32'h1000_0000};
    do_reset();
    push_words(80, 32'h5000_0000, 400, acc);
    wait_drain(80, "wrap");
    checks++;
    if (aw_log.size() != 5) begin
      errors++; $display("FAIL wrap_aw_count: got %0d required 5", aw_log.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (aw_log[i] !== exp_aw[i]) begin
        errors++; $display("FAIL wrap_awaddr%0d: got %h required %h", i, aw_log[i], exp_aw[i]);
      end
    end
    checks++;
    if (fd_cnt != 1 || fd_at != 4) begin
      errors++; $display("FAIL wrap_frame_done: %0d pulses at B #%0d, required 1 pulse at B #4", fd_cnt, fd_at);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int aw_hi;
    int rdy_hi;
    do_reset();
    b_hold = 1'b1;
    push_words(128, 32'h7000_0000, 600, acc);
    checks++;
    if (acc != 128) begin
      errors++; $display("FAIL bp_accepted: got %0d words required 128", acc);
    end
    aw_hi = 0;
    rdy_hi = 0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awvalid) aw_hi++;
      if (in_ready) rdy_hi++;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (aw_hi != 0 || aw_log.size() != 4) begin
      errors++; $display("FAIL bp_aw_stall: %0d AW, awvalid high %0d cycles, required 4 AW and 0 cycles", aw_log.size(), aw_hi);
    end
    checks++;
    if (rdy_hi != 0) begin
      errors++; $display("FAIL bp_in_ready: high %0d cycles with 64 buffered, required 0", rdy_hi);
    end
    checks++;
    if (w_log.size() != 64) begin
      errors++; $display("FAIL bp_beats_held: got %0d beats required 64", w_log.size());
    end
    b_hold = 1'b0;
    wait_drain(128, "bp");
    checks++;
    if (aw_log.size() != 8 || aw_log[4] !== 32'h1000_0000 || aw_log[7] !== 32'h1000_00C0) begin
      errors++; $display("FAIL bp_aw_after: %0d AW, [4]=%h [7]=%h, required 8 AW with 10000000 and 100000c0",
                         aw_log.size(), aw_log[4], aw_log[7]);
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (w_log[i] !== 32'h7000_0000 + 32'(i)) begin
        errors++; $display("FAIL bp_data%0d: got %h required %h", i, w_log[i], 32'h7000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_wready_stall();
    int          acc;
    int          cyc;
    int          stall_at [2];
    logic [31:0] d0;
    logic        l0;
    stall_at = '{6, 31};
    do_reset();
    wready = 1'b0;
    push_words(32, 32'hA000_0000, 200, acc);
    wready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cyc = 0;
      while (w_log.size() < stall_at[s] && cyc < 200) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      wready = 1'b0;
      @(negedge clk);
      d0 = wdata;
      l0 = wlast;
      checks++;
      if (wvalid !== 1'b1 || d0 !== 32'hA000_0000 + 32'(stall_at[s]) || l0 !== (stall_at[s] % 16 == 15)) begin
        errors++;
        $display("FAIL stall%0d_head: wvalid=%b wdata=%h wlast=%b, required 1 %h %b", s, wvalid, d0, l0,
                 32'hA000_0000 + 32'(stall_at[s]), (stall_at[s] % 16 == 15));
      end
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        checks++;
        if (wvalid !== 1'b1 || wdata !== d0 || wlast !== l0) begin
          errors++;
          $display("FAIL stall%0d_hold%0d: wvalid=%b wdata=%h wlast=%b, required 1 %h %b", s, c, wvalid, wdata, wlast, d0, l0);
        end
      end
      @(posedge clk);
      #1;
      wready = 1'b1;
    end
    wait_drain(32, "stall");
    checks++;
    if (w_log.size() != 32) begin
      errors++; $display("FAIL stall_count: got %0d beats required 32", w_log.size());
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (w_log[i] !== 32'hA000_0000 + 32'(i) || wl_log[i] !== (i % 16 == 15)) begin
        errors++;
        $display("FAIL stall_beat%0d: data %h last %b, required %h %b", i, w_log[i], wl_log[i],
                 32'hA000_0000 + 32'(i), (i % 16 == 15));
      end
    end
  endtask

  task automatic test_bresp_error();
    int acc;
    do_reset();
    b_err_at = 2;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_initial: got %b required 0", err);
    end
    push_words(64, 32'hB000_0000, 300, acc);
    wait_drain(64, "err");
    checks++;
    if (err !== 1'b1 || b_cnt != 4) begin
      errors++; $display("FAIL err_set: err=%b after %0d B, required 1 after 4", err, b_cnt);
    end
    push_words(16, 32'hB000_0040, 100, acc);
    wait_drain(80, "err_after");
    checks++;
    if (err !== 1'b1 || w_log.size() != 80 || b_cnt != 5) begin
      errors++; $display("FAIL err_sticky: err=%b beats=%0d B=%0d, required 1 80 5", err, w_log.size(), b_cnt);
    end
  endtask

  task automatic test_reset_midburst();
    int acc;
    int cyc;
    do_reset();
    wready = 1'b0;
    push_words(16, 32'hC000_0000, 100, acc);
    wready = 1'b1;
    cyc = 0;
    while (w_log.size() < 7 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (wvalid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: wvalid=%b before reset, required 1", wvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || wlast !== 1'b0) begin
      errors++; $display("FAIL midrst_immediate: awvalid=%b wvalid=%b wlast=%b, required 0 0 0", awvalid, wvalid, wlast);
    end
    do_reset();
    push_words(16, 32'hD000_0000, 100, acc);
    wait_drain(16, "midrst");
    checks++;
    if (aw_log.size() != 1 || aw_log[0] !== 32'h1000_0000 || w_log[0] !== 32'hD000_0000) begin
      errors++; $display("FAIL midrst_restart: %0d AW first %h, first beat %h, required 1 AW 10000000 and d0000000",
                         aw_log.size(), aw_log[0], w_log[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_frame_wrap();
    test_backpressure();
    test_wready_stall();
    test_bresp_error();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
